icache_line_server: RTL and testbench

Memory-side responder for the instruction-cache refill interface. It accepts a line-refill request from the I-cache miss handler and reads one 64-byte line (`icache_blocksize`) from a byte-wide synchronous instruction memory (`memory_word` = 8). It assembles the bytes into 32-bit instruction words (`instr_size`) and streams 16 beats back with valid/ready flow control. Words are returned critical-word-first, wrapping around within the line.

---
 rtl/icache_line_server_pkg.sv | 29 ++
 rtl/icache_line_server_if.sv | 39 +++
 rtl/icache_line_server_word_assembler.sv | 41 ++++
 rtl/icache_line_server.sv | 150 +++++++++++++++
 tb/tb_icache_line_server.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_line_server_pkg.sv
// Shared constants for the instruction-cache refill path.
// Holds the base cache/memory geometry, the line-server sizes derived from it,
// and the line-server state encoding.
// No ports: this file is a package only.
`ifndef ICACHE_LINEBEATS
`define ICACHE_LINEBEATS 16
`endif

package icache_line_server_pkg;

  // Base geometry, all expressed in bits.
  localparam int pc_size          = 32;
  localparam int icache_blocksize = 512;
  localparam int instr_size       = 32;
  localparam int memory_word      = 8;

  // Sizes derived from the base geometry.
  localparam int icache_linebeats = `ICACHE_LINEBEATS;
  localparam int line_bytes       = icache_blocksize / memory_word;  // 64
  localparam int word_bytes       = instr_size / memory_word;        // 4

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_FETCH,
    LS_DRAIN,
    LS_SEND
  } line_srv_state;

endpackage

// File: rtl/icache_line_server_if.sv
// Refill bus between the I-cache miss handler, the instruction memory and
// the line server.
//   flush                       : abort the line in flight
//   req_valid/req_ready/req_addr: line refill request
//   mem_en/mem_addr/mem_rdata   : byte-wide synchronous memory read port
//   rsp_valid/rsp_ready         : response beat handshake
//   rsp_data/rsp_word/rsp_last  : beat payload
// The slave modport is the line server; the master modport is the cache and
// memory side.
interface icache_line_server_if
  import icache_line_server_pkg::*;
#(
  parameter int ADDR_W = pc_size
) ();

  logic                           flush;
  logic                           req_valid;
  logic                           req_ready;
  logic [ADDR_W-1:0]              req_addr;
  logic                           mem_en;
  logic [ADDR_W-1:0]              mem_addr;
  logic [memory_word-1:0]         mem_rdata;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [instr_size-1:0]          rsp_data;
  logic [$clog2(icache_linebeats)-1:0] rsp_word;
  logic                           rsp_last;

  modport slave (
    input  flush, req_valid, req_addr, mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_addr, rsp_valid, rsp_data, rsp_word, rsp_last
  );

  modport master (
    output flush, req_valid, req_addr, mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_addr, rsp_valid, rsp_data, rsp_word, rsp_last
  );

endinterface

// File: rtl/icache_line_server_word_assembler.sv
// Byte-lane register that assembles one instruction word from byte reads.
//   clk     : clock
//   clear   : synchronous clear of every lane
//   wr_en   : write one lane this cycle
//   wr_lane : lane selected by wr_en (lane k holds bits [8k+7:8k])
//   wr_byte : byte written into the selected lane
//   word    : registered assembled word (little-endian)
module icache_line_server_word_assembler
  import icache_line_server_pkg::*;
#(
  parameter int LANES     = word_bytes,
  parameter int LANE_BITS = memory_word
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [$clog2(LANES)-1:0]     wr_lane,
  input  logic [LANE_BITS-1:0]         wr_byte,
  output logic [LANES*LANE_BITS-1:0]   word
);

  localparam int SEL_W = $clog2(LANES);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_BITS-1:0] lane_reg;

      always_ff @(posedge clk) begin
        if (clear) begin
          lane_reg <= '0;
        end else if (wr_en && (wr_lane == SEL_W'(gi))) begin
          lane_reg <= wr_byte;
        end
      end

      assign word[gi*LANE_BITS +: LANE_BITS] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_line_server.sv
// Memory-side responder for I-cache line refills. Reads one line byte by
// byte from a synchronous instruction memory, packs the bytes into 32-bit
// words and returns them critical-word-first, wrapping within the line.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : refill bus (slave side): request, memory port, response beats
module icache_line_server
  import icache_line_server_pkg::*;
#(
  parameter int ADDR_W     = pc_size,
  parameter int LINE_BYTES = line_bytes,
  parameter int WORD_BYTES = word_bytes
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_line_server_if.slave  bus
);

  localparam int BEATS  = LINE_BYTES / WORD_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int WIDX_W = $clog2(BEATS);
  localparam int LANE_W = $clog2(WORD_BYTES);

  line_srv_state          state_reg;
  logic [ADDR_W-OFF_W-1:0] base_reg;
  logic [WIDX_W-1:0]      start_word_reg;
  logic [WIDX_W-1:0]      beat_cnt_reg;
  logic [LANE_W-1:0]      k_reg;
  logic                   mem_en_reg;
  logic [ADDR_W-1:0]      mem_addr_reg;
  logic                   rsp_valid_reg;
  logic [WIDX_W-1:0]      rsp_word_reg;
  logic                   rsp_last_reg;

  // Word being fetched; the 4-bit add wraps inside the line.
  logic [WIDX_W-1:0] word_idx;
  assign word_idx = start_word_reg + beat_cnt_reg;

  // Byte offset bits of the request address are not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[LANE_W-1:0];

  assign bus.req_ready = (state_reg == LS_IDLE) & ~bus.flush & rst_n;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_word  = rsp_word_reg;
  assign bus.rsp_last  = rsp_last_reg;

  // Read data trails mem_en by one cycle, so FETCH byte k captures lane k-1
  // and DRAIN picks up the final lane.
  logic              asm_we;
  logic [LANE_W-1:0] asm_lane;

  always_comb begin
    asm_we   = 1'b0;
    asm_lane = '0;
    if (state_reg == LS_FETCH && k_reg != '0) begin
      asm_we   = 1'b1;
      asm_lane = k_reg - LANE_W'(1);
    end else if (state_reg == LS_DRAIN) begin
      asm_we   = 1'b1;
      asm_lane = LANE_W'(WORD_BYTES - 1);
    end
  end

  icache_line_server_word_assembler #(
    .LANES     (WORD_BYTES),
    .LANE_BITS (memory_word)
  ) u_word_assembler (
    .clk     (clk),
    .clear   (~rst_n),
    .wr_en   (asm_we),
    .wr_lane (asm_lane),
    .wr_byte (bus.mem_rdata),
    .word    (bus.rsp_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= LS_IDLE;
      base_reg       <= '0;
      start_word_reg <= '0;
      beat_cnt_reg   <= '0;
      k_reg          <= '0;
      mem_en_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_word_reg   <= '0;
      rsp_last_reg   <= 1'b0;
    end else if (bus.flush) begin
      // A beat handshaking this cycle is already delivered; the rest of the
      // line is dropped. Late memory bytes land while idle and are ignored.
      state_reg     <= LS_IDLE;
      mem_en_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        LS_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            base_reg       <= bus.req_addr[ADDR_W-1:OFF_W];
            start_word_reg <= bus.req_addr[OFF_W-1:LANE_W];
            beat_cnt_reg   <= '0;
            k_reg          <= '0;
            mem_en_reg     <= 1'b1;
            mem_addr_reg   <= {bus.req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            state_reg      <= LS_FETCH;
          end
        end

        LS_FETCH: begin
          if (k_reg == LANE_W'(WORD_BYTES - 1)) begin
            mem_en_reg <= 1'b0;
            state_reg  <= LS_DRAIN;
          end else begin
            k_reg        <= k_reg + LANE_W'(1);
            mem_addr_reg <= {base_reg, word_idx, k_reg + LANE_W'(1)};
          end
        end

        LS_DRAIN: begin
          rsp_valid_reg <= 1'b1;
          rsp_word_reg  <= word_idx;
          rsp_last_reg  <= (beat_cnt_reg == WIDX_W'(BEATS - 1));
          state_reg     <= LS_SEND;
        end

        LS_SEND: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            if (beat_cnt_reg == WIDX_W'(BEATS - 1)) begin
              state_reg <= LS_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + WIDX_W'(1);
              k_reg        <= '0;
              mem_en_reg   <= 1'b1;
              mem_addr_reg <= {base_reg, word_idx + WIDX_W'(1), LANE_W'(0)};
              state_reg    <= LS_FETCH;
            end
          end
        end

        default: state_reg <= LS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_server.sv
module tb_icache_line_server;
  import icache_line_server_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  icache_line_server_if bus ();

  icache_line_server dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: byte at address A is A[7:0], one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= bus.mem_addr[7:0];
  end

  typedef struct packed {
    logic [3:0]  w;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    last_hs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every handshake pops one expected beat.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      beat_t g;
      beat_t e;
      g.w = bus.rsp_word;
      g.d = bus.rsp_data;
      g.l = bus.rsp_last;
      got_q.push_back(g);
      last_hs_cyc = cyc;
      $display("[TB] beat word=%0d data=0x%08h last=%0b cycle=%0d", g.w, g.d, g.l, cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_word", g.w, e.w);
        chk("beat_data", g.d, e.d);
        chk("beat_last", g.l, e.l);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats for a line request, critical word first.
  task automatic push_line(input logic [31:0] addr);
    logic [31:0] base;
    logic [31:0] a;
    logic [3:0]  w;
    beat_t       e;
    base = addr & 32'hFFFF_FFC0;
    for (int b = 0; b < 16; b++) begin
      w = addr[5:2] + 4'(b);
      for (int k = 0; k < 4; k++) begin
        a = base + {26'd0, w, 2'b00} + 32'(k);
        e.d[8*k +: 8] = a[7:0];
      end
      e.w = w;
      e.l = (b == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_req(input logic [31:0] addr, output int acc);
    int n;
    acc = -1;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    #1;
    while (acc < 0 && n < 20) begin
      if (bus.req_ready) begin
        acc = cyc;
        push_line(addr);
      end
      step();
      n++;
    end
    bus.req_valid = 1'b0;
    $display("[TB] request 0x%08h accepted at cycle %0d", addr, acc);
    if (acc < 0) begin
      chk("req_accept_timeout", 0, 1);
    end else begin
      chk("first_mem_en", bus.mem_en, 1);
      chk("first_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
    end
  endtask

  task automatic wait_done(input logic [31:0] lo, input logic [31:0] hi, output int oor);
    int n;
    n = 0;
    oor = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
      if (bus.mem_en && (bus.mem_addr < lo || bus.mem_addr > hi)) oor++;
    end
    chk("line_done_timeout", exp_q.size(), 0);
    chk("req_ready_after_line", bus.req_ready, 1);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (got_q.size() < target && n < 200) begin
      step();
      n++;
    end
    chk("wait_beats_timeout", got_q.size(), target);
  endtask

  initial begin
    int acc;
    int oor;
    int c0;
    int n;
    int seen;
    logic [31:0] d0;
    logic [3:0]  w0;

    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_word", bus.rsp_word, 0);
    chk("rst_rsp_last", bus.rsp_last, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", bus.req_ready, 1);

    // Aligned line, no back-pressure
    got_q.delete();
    send_req(32'h0000_1000, acc);
    wait_done(32'h1000, 32'h103F, oor);
    chk("t1_beats", got_q.size(), 16);
    chk("t1_beat0_word", got_q[0].w, 0);
    chk("t1_beat0_data", got_q[0].d, 32'h03020100);
    chk("t1_beat15_word", got_q[15].w, 15);
    chk("t1_beat15_data", got_q[15].d, 32'h3F3E3D3C);
    chk("t1_beat15_last", got_q[15].l, 1);
    chk("t1_latency", last_hs_cyc - acc, 96);

    // Critical word 14, wrapping
    got_q.delete();
    send_req(32'h0000_1038, acc);
    wait_done(32'h1000, 32'h103F, oor);
    chk("t2_beats", got_q.size(), 16);
    chk("t2_word0", got_q[0].w, 14);
    chk("t2_word1", got_q[1].w, 15);
    chk("t2_word2", got_q[2].w, 0);
    chk("t2_beat0_data", got_q[0].d, 32'h3B3A3938);
    chk("t2_beat2_data", got_q[2].d, 32'h03020100);
    chk("t2_last_word", got_q[15].w, 13);
    chk("t2_last_data", got_q[15].d, 32'h37363534);
    chk("t2_last_flag", got_q[15].l, 1);
    chk("t2_addr_range", oor, 0);

    // Back-pressure during beat 3
    got_q.delete();
    send_req(32'h0000_1000, acc);
    wait_beats(3);
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk("t3_valid_rise", bus.rsp_valid, 1);
    d0 = bus.rsp_data;
    w0 = bus.rsp_word;
    chk("t3_word", w0, 3);
    chk("t3_data", d0, 32'h0F0E0D0C);
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_hold", {bus.rsp_valid, bus.rsp_word, bus.rsp_data, bus.mem_en},
          {1'b1, w0, d0, 1'b0});
      step();
    end
    bus.rsp_ready = 1'b1;
    wait_done(32'h1000, 32'h103F, oor);
    chk("t3_beats", got_q.size(), 16);

    // Flush while beat 5 is fetching
    got_q.delete();
    send_req(32'h0000_1000, acc);
    wait_beats(5);
    step();
    chk("t4_in_fetch", bus.mem_en, 1);
    bus.flush = 1'b1;
    #1;
    chk("t4_req_ready_during_flush", bus.req_ready, 0);
    step();
    bus.flush = 1'b0;
    #1;
    chk("t4_rsp_valid_after_flush", bus.rsp_valid, 0);
    chk("t4_mem_en_after_flush", bus.mem_en, 0);
    chk("t4_req_ready_after_flush", bus.req_ready, 1);
    exp_q.delete();
    got_q.delete();
    repeat (3) step();
    chk("t4_no_beats_after_flush", got_q.size(), 0);
    send_req(32'h0000_2004, acc);
    wait_done(32'h2000, 32'h203F, oor);
    chk("t4_new_beats", got_q.size(), 16);
    chk("t4_new_word0", got_q[0].w, 1);
    chk("t4_new_data0", got_q[0].d, 32'h07060504);
    chk("t4_new_last_word", got_q[15].w, 0);
    chk("t4_new_last_data", got_q[15].d, 32'h03020100);

    // flush and req_valid together in idle
    got_q.delete();
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_3000;
    #1;
    chk("t5_req_ready_flush", bus.req_ready, 0);
    step();
    chk("t5_no_mem_en", bus.mem_en, 0);
    bus.flush = 1'b0;
    c0 = cyc;
    send_req(32'h0000_3000, acc);
    chk("t5_accept_next_cycle", acc, c0);
    wait_done(32'h3000, 32'h303F, oor);
    chk("t5_beats", got_q.size(), 16);

    // Reset in the middle of a fetch
    got_q.delete();
    send_req(32'h0000_1000, acc);
    step();
    rst_n = 1'b0;
    step();
    chk("t6_mem_en", bus.mem_en, 0);
    chk("t6_mem_addr", bus.mem_addr, 0);
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_rsp_data", bus.rsp_data, 0);
    chk("t6_rsp_word", bus.rsp_word, 0);
    chk("t6_rsp_last", bus.rsp_last, 0);
    chk("t6_req_ready_in_reset", bus.req_ready, 0);
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_req_ready_after", bus.req_ready, 1);
    seen = 0;
    repeat (20) begin
      step();
      if (bus.rsp_valid || bus.mem_en) seen++;
    end
    chk("t6_no_stale_activity", seen, 0);
    chk("t6_no_stale_beats", got_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
